mw_wdata_stage: RTL and testbench
=================================

Name: mw_wdata_stage

Overview:
- Parametrised successor to the M-stage writeback-data selector.
- Selects one of NSRC M-stage result sources, adds the link offset for link instructions, and byte/half-extends memory load data.
- Registers the result with destination and write-enable into the M/W pipeline register, under stall/flush control.
- Also provides a combinational forwarding copy and a saturating writeback-commit counter.

Parameters:
- WIDTH, 32: datapath width; must be >= 32; load extension acts on the low 32 bits.
- NSRC, 4: number of result sources; source 0 = ALU ans, 1 = memory Rdata, 2 = adder/PC, others user-defined.
- SEL_W, 2: select width; 2^SEL_W >= NSRC.
- ADDR_W, 5: register-address width.
- LINK_SRC, 2: source index that receives the link offset.
- LINK_OFFSET, 8: value added to source LINK_SRC when M_is_link=1.
- MEM_SRC, 1: source index subject to load extension.
- CNT_W, 32: commit-counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- M_src  in  NSRC*WIDTH  flattened sources; source i is bits [i*WIDTH +: WIDTH].
- s_M_GRF_Wdata  in  SEL_W  source select.
- M_is_link  in  1  link instruction (jal/jalr class).
- M_load_mode  in  3  000 word, 001 lbu, 010 lb, 011 lhu, 100 lh; 101-111 treated as word.
- M_byte_off  in  2  address low bits for load-lane select.
- M_GRF_A3  in  ADDR_W  destination register.
- M_GRF_WE  in  1  register write enable.
- stall  in  1  hold the W register.
- flush  in  1  insert a bubble into W.
- M_fwd_data  out  WIDTH  combinational final M-stage value, for forwarding.
- W_GRF_Wdata  out  WIDTH  registered writeback data.
- W_GRF_A3  out  ADDR_W  registered destination.
- W_GRF_WE  out  1  registered write enable.
- W_commit_cnt  out  CNT_W  saturating count of committed writes.

Behaviour:
- Select: sel = s_M_GRF_Wdata. If sel >= NSRC, use source 0.
- Link: if sel==LINK_SRC and M_is_link=1, add LINK_OFFSET modulo 2^WIDTH (wraps, no carry-out). Otherwise the source passes unmodified.
- Load extension: applies only when sel==MEM_SRC.
  - Byte lane = bits [8*M_byte_off +: 8].
  - Half lane = bits [16*M_byte_off[1] +: 16]; M_byte_off[0] is ignored for halves.
  - lbu/lhu zero-fill to WIDTH; lb/lh sign-fill to WIDTH; word passes unmodified.
- Zero-register rule: if M_GRF_A3==0, the effective WE is 0 and the data is forced to 0. This also applies to M_fwd_data, so forwarding never supplies a nonzero value for $0.
- M_fwd_data is purely combinational: zero-cycle latency from inputs.
- Register update, priority reset > flush > stall > load:
  - reset low (asynchronous): W_GRF_Wdata=0, W_GRF_A3=0, W_GRF_WE=0, W_commit_cnt=0, regardless of clk.
  - flush=1 at a rising edge: Wdata, A3 and WE all load 0. Flush wins over a simultaneous stall.
  - stall=1 (flush=0): all W outputs hold their values.
  - otherwise: load the effective Wdata, A3 and WE. One-cycle latency from M inputs to W outputs.
- Commit counter:
  - Increments on each rising edge where the W register is loaded (no flush, no stall) with effective WE=1.
  - Saturates at all-ones; no wrap.
  - Held during stall; not incremented by a flush.
- Reset deasserting mid-cycle: outputs stay 0 until the next qualifying edge.

Test Plan:
- Reset: assert reset=0 asynchronously mid-cycle with W outputs nonzero -> all W outputs and W_commit_cnt read 0 immediately, before any clock edge.
- Link: sel=2, M_src[2]=0x00003000, M_is_link=1, A3=31, WE=1 -> M_fwd_data=0x00003008; after 1 clk W_GRF_Wdata=0x00003008, W_GRF_A3=31, W_GRF_WE=1, count=1. Repeat with M_is_link=0 -> 0x00003000. Repeat with source 0xFFFFFFFC and link -> 0x00000004 (wrap).
- Load extension: sel=1, Rdata=0x80FF7F01:
  - lb, off=3 -> 0xFFFFFF80.
  - lbu, off=3 -> 0x00000080.
  - lh, off=2 -> 0xFFFF80FF.
  - lhu, off=0 -> 0x00007F01.
  - lb, off=1 -> 0x0000007F.
- Stall/flush: load A3=5 data=0x1234; then stall=1 for 3 cycles with new inputs -> W holds 0x1234/5/1 and count stays unchanged. Then stall=1 and flush=1 together -> W becomes 0/0/0 and count is not incremented.
- Zero register and out-of-range select: A3=0, WE=1, data 0xDEAD -> M_fwd_data=0; W shows WE=0, data=0; count unchanged. With NSRC=3 and sel=3 -> source 0 is selected.
- Saturation: CNT_W=4; perform 20 committed writes -> W_commit_cnt stops at 15.

Source files
------------

// File: rtl/mw_wdata_stage.sv
// ---------------------------------------------------------------------------
// mw_wdata_stage
//
// Purpose:
//   M-stage writeback-data selection and M/W pipeline register.
//   - picks one of NSRC M-stage results (out-of-range select falls back to
//     source 0),
//   - adds LINK_OFFSET to source LINK_SRC for link instructions,
//   - byte/half extends memory load data on source MEM_SRC,
//   - applies the $0 rule (A3==0 -> no write, data forced to 0),
//   - exposes the final value combinationally for forwarding,
//   - registers data/A3/WE into W under flush/stall control,
//   - keeps a saturating count of committed register writes.
//
// Pipeline control (single contract for this stage):
//   flush=1 at a rising edge loads a bubble (0/0/0) and wins over stall.
//   stall=1 (flush=0) holds every W output and the commit counter.
//   Otherwise W loads the effective M value; the counter advances when the
//   loaded WE is 1, stopping at all-ones.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   M_src          in   NSRC*WIDTH flattened sources, source i at [i*WIDTH +: WIDTH]
//   s_M_GRF_Wdata  in   source select
//   M_is_link      in   link instruction
//   M_load_mode    in   000 word, 001 lbu, 010 lb, 011 lhu, 100 lh, others word
//   M_byte_off     in   address low bits for the load lane
//   M_GRF_A3       in   destination register
//   M_GRF_WE       in   register write enable
//   stall          in   hold the W register
//   flush          in   insert a bubble into W
//   M_fwd_data     out  combinational final M value (forwarding)
//   W_GRF_Wdata    out  registered writeback data
//   W_GRF_A3       out  registered destination
//   W_GRF_WE       out  registered write enable
//   W_commit_cnt   out  saturating committed-write count
//
// WIDTH must be >= 32; load extension looks only at the low 32 bits.
// ---------------------------------------------------------------------------
module mw_wdata_stage #(
  parameter int WIDTH       = 32,
  parameter int NSRC        = 4,
  parameter int SEL_W       = 2,
  parameter int ADDR_W      = 5,
  parameter int LINK_SRC    = 2,
  parameter int LINK_OFFSET = 8,
  parameter int MEM_SRC     = 1,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSRC*WIDTH-1:0] M_src,
  input  logic [SEL_W-1:0]      s_M_GRF_Wdata,
  input  logic                  M_is_link,
  input  logic [2:0]            M_load_mode,
  input  logic [1:0]            M_byte_off,
  input  logic [ADDR_W-1:0]     M_GRF_A3,
  input  logic                  M_GRF_WE,
  input  logic                  stall,
  input  logic                  flush,
  output logic [WIDTH-1:0]      M_fwd_data,
  output logic [WIDTH-1:0]      W_GRF_Wdata,
  output logic [ADDR_W-1:0]     W_GRF_A3,
  output logic                  W_GRF_WE,
  output logic [CNT_W-1:0]      W_commit_cnt
);

  localparam logic [2:0] LD_LBU = 3'b001;
  localparam logic [2:0] LD_LB  = 3'b010;
  localparam logic [2:0] LD_LHU = 3'b011;
  localparam logic [2:0] LD_LH  = 3'b100;

  logic [WIDTH-1:0]  src_sel;
  logic [WIDTH-1:0]  src_link;
  logic [WIDTH-1:0]  src_ext;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic              sel_is_link;
  logic              sel_is_mem;
  logic              a3_is_zero;
  logic              eff_we;

  logic [WIDTH-1:0]  w_wdata_d, w_wdata_q;
  logic [ADDR_W-1:0] w_a3_d,    w_a3_q;
  logic              w_we_d,    w_we_q;
  logic [CNT_W-1:0]  cnt_d,     cnt_q;

  // Source mux; any select with no matching source keeps source 0.
  always_comb begin
    src_sel = M_src[0 +: WIDTH];
    for (int i = 1; i < NSRC; i++) begin
      if (int'(s_M_GRF_Wdata) == i) src_sel = M_src[i*WIDTH +: WIDTH];
    end
  end

  assign sel_is_link = (int'(s_M_GRF_Wdata) == LINK_SRC) && M_is_link;
  assign sel_is_mem  = (int'(s_M_GRF_Wdata) == MEM_SRC);

  // Link offset wraps modulo 2^WIDTH.
  assign src_link = sel_is_link ? (src_sel + WIDTH'(LINK_OFFSET)) : src_sel;

  always_comb begin
    byte_lane = src_sel[7:0];
    case (M_byte_off)
      2'd0:    byte_lane = src_sel[7:0];
      2'd1:    byte_lane = src_sel[15:8];
      2'd2:    byte_lane = src_sel[23:16];
      default: byte_lane = src_sel[31:24];
    endcase
  end

  // Halfword lane ignores byte_off[0].
  assign half_lane = M_byte_off[1] ? src_sel[31:16] : src_sel[15:0];

  always_comb begin
    src_ext = src_link;
    if (sel_is_mem) begin
      case (M_load_mode)
        LD_LBU:  src_ext = {{(WIDTH-8){1'b0}}, byte_lane};
        LD_LB:   src_ext = {{(WIDTH-8){byte_lane[7]}}, byte_lane};
        LD_LHU:  src_ext = {{(WIDTH-16){1'b0}}, half_lane};
        LD_LH:   src_ext = {{(WIDTH-16){half_lane[15]}}, half_lane};
        default: src_ext = src_link;
      endcase
    end
  end

  // $0 is never written and never forwarded as nonzero.
  assign a3_is_zero = (M_GRF_A3 == '0);
  assign eff_we     = M_GRF_WE && !a3_is_zero;
  assign M_fwd_data = a3_is_zero ? '0 : src_ext;

  always_comb begin
    w_wdata_d = w_wdata_q;
    w_a3_d    = w_a3_q;
    w_we_d    = w_we_q;
    cnt_d     = cnt_q;
    if (flush) begin
      w_wdata_d = '0;
      w_a3_d    = '0;
      w_we_d    = 1'b0;
    end else if (!stall) begin
      w_wdata_d = M_fwd_data;
      w_a3_d    = M_GRF_A3;
      w_we_d    = eff_we;
      if (eff_we && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_wdata_q <= '0;
      w_a3_q    <= '0;
      w_we_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      w_wdata_q <= w_wdata_d;
      w_a3_q    <= w_a3_d;
      w_we_q    <= w_we_d;
      cnt_q     <= cnt_d;
    end
  end

  assign W_GRF_Wdata  = w_wdata_q;
  assign W_GRF_A3     = w_a3_q;
  assign W_GRF_WE     = w_we_q;
  assign W_commit_cnt = cnt_q;

endmodule

// File: tb/tb_mw_wdata_stage.sv
// ---------------------------------------------------------------------------
// tb_mw_wdata_stage
//
// Two instances: u_dut (default parameters) and u_dut2 (NSRC=3, CNT_W=4)
// sharing the same control inputs; u_dut2 sees the low three sources.
// Each step drives M inputs, checks the combinational forwarding value,
// pushes the expected W triple {data, a3, we} to exp_q, then after the
// clock edge pops it and compares against the W outputs and counters.
// ---------------------------------------------------------------------------
module tb_mw_wdata_stage;

  localparam int EXP_W = 38;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // stimulus
  logic [127:0] M_src;
  logic [1:0]   sel;
  logic         is_link;
  logic [2:0]   load_mode;
  logic [1:0]   byte_off;
  logic [4:0]   a3;
  logic         we;
  logic         stall;
  logic         flush;

  // dut outputs
  logic [31:0]  fwd, w_data;
  logic [4:0]   w_a3;
  logic         w_we;
  logic [31:0]  w_cnt;
  logic [31:0]  fwd2, w_data2;
  logic [4:0]   w_a32;
  logic         w_we2;
  logic [3:0]   w_cnt2;

  mw_wdata_stage u_dut (
    .clk(clk), .reset(reset), .M_src(M_src), .s_M_GRF_Wdata(sel),
    .M_is_link(is_link), .M_load_mode(load_mode), .M_byte_off(byte_off),
    .M_GRF_A3(a3), .M_GRF_WE(we), .stall(stall), .flush(flush),
    .M_fwd_data(fwd), .W_GRF_Wdata(w_data), .W_GRF_A3(w_a3),
    .W_GRF_WE(w_we), .W_commit_cnt(w_cnt)
  );

  mw_wdata_stage #(.NSRC(3), .CNT_W(4)) u_dut2 (
    .clk(clk), .reset(reset), .M_src(M_src[95:0]), .s_M_GRF_Wdata(sel),
    .M_is_link(is_link), .M_load_mode(load_mode), .M_byte_off(byte_off),
    .M_GRF_A3(a3), .M_GRF_WE(we), .stall(stall), .flush(flush),
    .M_fwd_data(fwd2), .W_GRF_Wdata(w_data2), .W_GRF_A3(w_a32),
    .W_GRF_WE(w_we2), .W_commit_cnt(w_cnt2)
  );

  // scoreboard
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] last_w;
  logic [31:0]      cnt_model;
  logic [3:0]       cnt2_model;
  int               errors = 0;
  int               checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    last_w     = '0;
    cnt_model  = '0;
    cnt2_model = '0;
  endtask

  // Drive one M-stage step, check forwarding, advance one clock, check W.
  task automatic step(input string tag,
                      input logic [31:0] s0, input logic [31:0] s1,
                      input logic [31:0] s2, input logic [31:0] s3,
                      input logic [1:0] sel_v, input logic link_v,
                      input logic [2:0] mode_v, input logic [1:0] off_v,
                      input logic [4:0] a3_v, input logic we_v,
                      input logic st_v, input logic fl_v,
                      input logic [31:0] exp_fwd);
    logic [EXP_W-1:0] exp_w;
    logic [EXP_W-1:0] got_w;
    logic             eff_we;
    M_src     = {s3, s2, s1, s0};
    sel       = sel_v;
    is_link   = link_v;
    load_mode = mode_v;
    byte_off  = off_v;
    a3        = a3_v;
    we        = we_v;
    stall     = st_v;
    flush     = fl_v;
    #1;
    chk({tag, "_fwd"}, 64'(fwd), 64'(exp_fwd));
    eff_we = we_v && (a3_v != 5'd0);
    if (fl_v) begin
      exp_w = '0;
    end else if (st_v) begin
      exp_w = last_w;
    end else begin
      exp_w = {exp_fwd, a3_v, eff_we};
      if (eff_we) begin
        cnt_model = cnt_model + 32'd1;
        if (cnt2_model != 4'hF) cnt2_model = cnt2_model + 4'd1;
      end
    end
    last_w = exp_w;
    exp_q.push_back(exp_w);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      exp_w = exp_q.pop_front();
      got_w = {w_data, w_a3, w_we};
      chk({tag, "_w"},    64'(got_w),  64'(exp_w));
      chk({tag, "_cnt"},  64'(w_cnt),  64'(cnt_model));
      chk({tag, "_cnt2"}, 64'(w_cnt2), 64'(cnt2_model));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"},  64'(w_data),  64'd0);
    chk({tag, "_a3"},    64'(w_a3),    64'd0);
    chk({tag, "_we"},    64'(w_we),    64'd0);
    chk({tag, "_cnt"},   64'(w_cnt),   64'd0);
    chk({tag, "_data2"}, 64'(w_data2), 64'd0);
    chk({tag, "_a32"},   64'(w_a32),   64'd0);
    chk({tag, "_we2"},   64'(w_we2),   64'd0);
    chk({tag, "_cnt2"},  64'(w_cnt2),  64'd0);
  endtask

  localparam logic [31:0] RD = 32'h80FF7F01;

  initial begin
    M_src = '0; sel = '0; is_link = 0; load_mode = '0; byte_off = '0;
    a3 = '0; we = 0; stall = 0; flush = 0;
    clear_model();

    // reset before any clock edge
    reset = 1'b0;
    #2;
    check_all_zero("por");
    @(negedge clk);
    reset = 1'b1;

    // link offset
    step("link",   0, 0, 32'h00003000, 0, 2'd2, 1, 3'b000, 2'd0, 5'd31, 1, 0, 0, 32'h00003008);
    step("nolink", 0, 0, 32'h00003000, 0, 2'd2, 0, 3'b000, 2'd0, 5'd31, 1, 0, 0, 32'h00003000);
    step("linkwr", 0, 0, 32'hFFFFFFFC, 0, 2'd2, 1, 3'b000, 2'd0, 5'd31, 1, 0, 0, 32'h00000004);
    // link flag on a non-link source passes unmodified
    step("linkal", 32'h00000100, 0, 0, 0, 2'd0, 1, 3'b000, 2'd0, 5'd9, 1, 0, 0, 32'h00000100);

    // load extension
    step("lb3",  0, RD, 0, 0, 2'd1, 0, 3'b010, 2'd3, 5'd3, 1, 0, 0, 32'hFFFFFF80);
    step("lbu3", 0, RD, 0, 0, 2'd1, 0, 3'b001, 2'd3, 5'd3, 1, 0, 0, 32'h00000080);
    step("lh2",  0, RD, 0, 0, 2'd1, 0, 3'b100, 2'd2, 5'd3, 1, 0, 0, 32'hFFFF80FF);
    step("lhu0", 0, RD, 0, 0, 2'd1, 0, 3'b011, 2'd0, 5'd3, 1, 0, 0, 32'h00007F01);
    step("lb1",  0, RD, 0, 0, 2'd1, 0, 3'b010, 2'd1, 5'd3, 1, 0, 0, 32'h0000007F);
    step("lh3",  0, RD, 0, 0, 2'd1, 0, 3'b100, 2'd3, 5'd3, 1, 0, 0, 32'hFFFF80FF);
    step("lw",   0, RD, 0, 0, 2'd1, 0, 3'b000, 2'd2, 5'd3, 1, 0, 0, RD);
    step("l101", 0, RD, 0, 0, 2'd1, 0, 3'b101, 2'd3, 5'd3, 1, 0, 0, RD);
    // load mode on a non-memory source is ignored
    step("lbalu", RD, 0, 0, 0, 2'd0, 0, 3'b010, 2'd3, 5'd3, 1, 0, 0, RD);
    // WE=0 loads but does not count
    step("we0",  32'h55, 0, 0, 0, 2'd0, 0, 3'b000, 2'd0, 5'd6, 0, 0, 0, 32'h55);

    // stall / flush
    step("ld5",   32'h1234, 0, 0, 0, 2'd0, 0, 3'b000, 2'd0, 5'd5, 1, 0, 0, 32'h1234);
    for (int i = 0; i < 3; i++)
      step("stall", 32'hAAAA, 0, 0, 0, 2'd0, 0, 3'b000, 2'd0, 5'd7, 1, 1, 0, 32'hAAAA);
    step("stfl",  32'hBBBB, 0, 0, 0, 2'd0, 0, 3'b000, 2'd0, 5'd8, 1, 1, 1, 32'hBBBB);
    step("fl",    32'hCCCC, 0, 0, 0, 2'd0, 0, 3'b000, 2'd0, 5'd8, 1, 0, 1, 32'hCCCC);

    // zero register
    step("r0",    32'hDEAD, 0, 0, 0, 2'd0, 0, 3'b000, 2'd0, 5'd0, 1, 0, 0, 32'h0);

    // out-of-range select on the 3-source instance falls back to source 0
    step("sel3", 32'h1111, 0, 0, 32'h5555, 2'd3, 0, 3'b000, 2'd0, 5'd4, 1, 0, 0, 32'h5555);
    chk("sel3_fwd2", 64'(fwd2), 64'h1111);

    // asynchronous reset mid-cycle while W holds nonzero values
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async");
    clear_model();
    @(negedge clk);
    reset = 1'b1;

    // saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      logic [31:0] d;
      logic [4:0]  r;
      d = $urandom;
      r = 5'($urandom_range(1, 31));
      step("sat", d, 0, 0, 0, 2'd0, 0, 3'b000, 2'($urandom_range(0, 3)), r, 1, 0, 0, d);
    end
    chk("sat_final2", 64'(w_cnt2), 64'd15);
    chk("sat_final",  64'(w_cnt),  64'd20);
    // stalled and flushed cycles never advance a saturated counter
    step("satst", 32'h1, 0, 0, 0, 2'd0, 0, 3'b000, 2'd0, 5'd1, 1, 1, 0, 32'h1);
    step("satfl", 32'h1, 0, 0, 0, 2'd0, 0, 3'b000, 2'd0, 5'd1, 1, 0, 1, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
